// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Payload handed to the decoder, one entry per buffered instruction.
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic            fault;
  } if_payload_t;

  localparam int unsigned PayloadW = $bits(if_payload_t);

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if_fifo.sv
// Synchronous FIFO with flush; used both for the instruction buffer and the pc-tag queue.
module instr_fetch_unit_if_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 65
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [Width-1:0]        wdata,
  input  logic                    pop,
  output logic [Width-1:0]        rdata,
  output logic [$clog2(Depth):0]  count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_en, pop_en;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    push_en  = push & ~flush;
    pop_en   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(push_en) - (PtrW+1)'(pop_en);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; count alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push onto a full buffer is only safe when the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(push_en && !pop_en && count_q == (PtrW+1)'(Depth)));

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues word fetches, buffers returned words for the decoder.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ibus_req_valid,
  input  logic            ibus_req_ready,
  output logic [XLEN-1:0] ibus_req_addr,
  input  logic            ibus_rsp_valid,
  input  logic [XLEN-1:0] ibus_rsp_data,
  input  logic            ibus_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            rst_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] oc_q, oc_d;
  logic [CntW-1:0] dc_q, dc_d;
  logic [CntW-1:0] fc, tag_count;
  logic [CntW:0]   inflight;
  logic            req_fire, push, pop;
  logic [XLEN-1:0] tag_pc;
  if_payload_t     push_data, head;

  // Outstanding plus buffered words may never exceed the buffer, so responses always fit.
  assign inflight       = {1'b0, oc_q} + {1'b0, fc};
  assign ibus_req_valid = ~rst_q & ~redirect_valid & (inflight < (CntW+1)'(FIFO_DEPTH));
  assign ibus_req_addr  = pc_q;
  assign req_fire       = ibus_req_valid & ibus_req_ready;

  assign if_valid = (fc != '0) & ~redirect_valid;
  assign pop      = if_valid & if_ready;
  // Responses belonging to a pre-redirect stream are dropped while dc is non-zero.
  assign push     = ibus_rsp_valid & (dc_q == '0) & ~redirect_valid;

  assign push_data = '{instruction: ibus_rsp_data, pc: tag_pc, fault: ibus_rsp_err};
  assign if_instruction = head.instruction;
  assign if_pc          = head.pc;
  assign if_fault       = head.fault;

  // Next PC, outstanding and discard counts; a redirect overrides sequential fetch.
  always_comb begin
    oc_d = oc_q + CntW'(req_fire) - CntW'(ibus_rsp_valid);
    pc_d = pc_q;
    dc_d = dc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
      dc_d = oc_d;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (ibus_rsp_valid && dc_q != '0) dc_d = dc_q - CntW'(1);
    end
  end

  // Fetch state register; rst_q holds off the first request for a cycle after reset.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pc_q <= RESET_PC;
      oc_q <= '0;
      dc_q <= '0;
    end else begin
      pc_q <= pc_d;
      oc_q <= oc_d;
      dc_q <= dc_d;
    end
  end

  // Request addresses in flight; in-order responses retire them one per response.
  instr_fetch_unit_if_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (XLEN)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (ibus_rsp_valid),
    .rdata (tag_pc),
    .count (tag_count)
  );

  instr_fetch_unit_if_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PayloadW)
  ) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .count (fc)
  );

  assert property (@(posedge clk) disable iff (rst) tag_count == oc_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: bus responder, scoreboard and scenario tasks.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_req_valid;
  logic        bus_ready = 1'b1;
  logic [31:0] ibus_req_addr;
  logic        ibus_rsp_valid = 1'b0;
  logic [31:0] ibus_rsp_data = '0;
  logic        ibus_rsp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ibus_req_valid (ibus_req_valid),
    .ibus_req_ready (bus_ready),
    .ibus_req_addr  (ibus_req_addr),
    .ibus_rsp_valid (ibus_rsp_valid),
    .ibus_rsp_data  (ibus_rsp_data),
    .ibus_rsp_err   (ibus_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  typedef struct { logic [31:0] addr; int epoch; } pend_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic fault; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] dlv_pc[$];
  logic        dlv_fault[$];
  int          dlv_cyc[$];

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          bus_credit = -1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic        prev_rst = 1'b1;
  logic        exp_req, exp_ifv;
  pend_t       p;
  exp_t        e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_addr.size()) ? acc_addr[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic int acyc(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -100;
  endfunction
  function automatic logic [31:0] dpc(input int i);
    return (i < dlv_pc.size()) ? dlv_pc[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic int dcyc(input int i);
    return (i < dlv_cyc.size()) ? dlv_cyc[i] : -200;
  endfunction
  function automatic logic dflt(input int i);
    return (i < dlv_fault.size()) ? dlv_fault[i] : 1'bx;
  endfunction

  // Monitor and scoreboard: samples mid-cycle the events of the coming clock edge.
  always begin
    @(negedge clk);
    if (rst) begin
      pend.delete(); sb.delete();
      acc_addr.delete(); acc_cyc.delete();
      dlv_pc.delete(); dlv_fault.delete(); dlv_cyc.delete();
      exp_pc = RST_PC;
      cyc = 0;
      epoch++;
    end else begin
      cyc++;
      exp_ifv = (sb.size() != 0) && !redirect_valid;
      exp_req = !prev_rst && !redirect_valid && (pend.size() + sb.size() < DEPTH);
      n_checks++;
      if (if_valid !== exp_ifv)
        $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, exp_ifv);
      else n_pass++;
      n_checks++;
      if (ibus_req_valid !== exp_req)
        $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, ibus_req_valid, exp_req);
      else n_pass++;
      if (ibus_req_valid === 1'b1 && bus_ready) begin
        n_checks++;
        if (ibus_req_addr !== exp_pc)
          $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, ibus_req_addr, exp_pc);
        else n_pass++;
        pend.push_back('{addr: ibus_req_addr, epoch: epoch});
        acc_addr.push_back(ibus_req_addr);
        acc_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
      end
      if (if_valid === 1'b1 && if_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL deliver cyc=%0d got pc=%h exp=nothing", cyc, if_pc);
        end else begin
          e = sb.pop_front();
          if (if_instruction !== e.instr || if_pc !== e.pc || if_fault !== e.fault)
            $display("FAIL deliver cyc=%0d got {%h,%h,%b} exp {%h,%h,%b}", cyc,
                     if_instruction, if_pc, if_fault, e.instr, e.pc, e.fault);
          else n_pass++;
        end
        dlv_pc.push_back(if_pc);
        dlv_fault.push_back(if_fault);
        dlv_cyc.push_back(cyc);
      end
      if (ibus_rsp_valid && pend.size() != 0) begin
        p = pend.pop_front();
        // Only responses for the current fetch stream, not arriving with a redirect, survive.
        if (!redirect_valid && p.epoch == epoch)
          sb.push_back('{instr: mem_word(p.addr), pc: p.addr, fault: ibus_rsp_err});
      end
      if (redirect_valid) begin
        sb.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
        epoch++;
      end
    end
    prev_rst = rst;
  end

  // Instruction bus responder: in order, earliest one cycle after accept, gated by credit.
  always begin
    @(posedge clk);
    #1;
    if (pend.size() != 0 && bus_credit != 0) begin
      ibus_rsp_valid = 1'b1;
      ibus_rsp_data  = mem_word(pend[0].addr);
      ibus_rsp_err   = err_en && (pend[0].addr == err_addr);
      if (bus_credit > 0) bus_credit--;
    end else begin
      ibus_rsp_valid = 1'b0;
      ibus_rsp_data  = '0;
      ibus_rsp_err   = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int credit);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    bus_credit = credit;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    if_ready = 1'b1;
    bus_credit = -1;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    n_checks++;
    if (ibus_req_valid !== 1'b0 || if_valid !== 1'b0)
      $display("FAIL reset_idle got req=%b ifv=%b exp req=0 ifv=0", ibus_req_valid, if_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_req_valid !== 1'b0)
      $display("FAIL reset_release_gap got req=%b exp=0", ibus_req_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ibus_req_valid !== 1'b1 || ibus_req_addr !== RST_PC)
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h",
               ibus_req_valid, ibus_req_addr, RST_PC);
    else n_pass++;
    step(1);
  endtask

  task automatic test_sequential();
    do_reset(-1);
    if_ready = 1'b1;
    step(14);
    n_checks++;
    if (acc_at(0) !== 32'h0 || acc_at(1) !== 32'h4 || acc_at(2) !== 32'h8 ||
        acyc(1) != acyc(0) + 1 || acyc(0) != 2)
      $display("FAIL seq_req got %h@%0d %h@%0d %h exp 0@2 4@3 8", acc_at(0), acyc(0),
               acc_at(1), acyc(1), acc_at(2));
    else n_pass++;
    n_checks++;
    if (dpc(0) !== 32'h0 || dpc(1) !== 32'h4 || dpc(2) !== 32'h8)
      $display("FAIL seq_order got %h %h %h exp 0 4 8", dpc(0), dpc(1), dpc(2));
    else n_pass++;
    n_checks++;
    if (dcyc(0) != acyc(0) + 2 || dcyc(1) != dcyc(0) + 1)
      $display("FAIL seq_latency got first=%0d second=%0d exp first=%0d second=%0d",
               dcyc(0), dcyc(1), acyc(0) + 2, acyc(0) + 3);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(-1);
    if_ready = 1'b0;
    step(10);
    n_checks++;
    if (acc_addr.size() != 2)
      $display("FAIL stall_accepts got %0d exp 2", acc_addr.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ibus_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0)
      $display("FAIL stall_hold got req=%b ifv=%b pc=%h exp req=0 ifv=1 pc=0",
               ibus_req_valid, if_valid, if_pc);
    else n_pass++;
    @(posedge clk);
    #1;
    if_ready = 1'b1;
    step(12);
    n_checks++;
    if (dpc(0) !== 32'h0 || dpc(1) !== 32'h4 || dpc(2) !== 32'h8 || acc_at(2) !== 32'h8)
      $display("FAIL stall_resume got %h %h %h req2=%h exp 0 4 8 req2=8",
               dpc(0), dpc(1), dpc(2), acc_at(2));
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    do_reset(0);
    if_ready = 1'b1;
    step(6);
    @(negedge clk);
    n_checks++;
    if (acc_addr.size() != 2 || ibus_req_valid !== 1'b0)
      $display("FAIL hold_two got accepts=%0d req=%b exp 2 0", acc_addr.size(), ibus_req_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    bus_credit = -1;
    step(12);
    n_checks++;
    if (dpc(0) !== 32'h100 || dpc(1) !== 32'h104 || acc_at(2) !== 32'h100)
      $display("FAIL redirect_target got %h %h req2=%h exp 100 104 req2=100",
               dpc(0), dpc(1), acc_at(2));
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(0);
    if_ready = 1'b1;
    step(6);
    @(negedge clk);
    #2;
    bus_credit = 1;
    step(6);
    n_checks++;
    if (acc_addr.size() != 3 || acc_at(2) !== 32'h8 || dpc(0) !== 32'h0)
      $display("FAIL pre_redirect got accepts=%0d req2=%h dlv0=%h exp 3 8 0",
               acc_addr.size(), acc_at(2), dpc(0));
    else n_pass++;
    @(negedge clk);
    #2;
    bus_credit = 1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || ibus_req_valid !== 1'b0 || ibus_rsp_valid !== 1'b1)
      $display("FAIL redirect_cycle got ifv=%b req=%b rsp=%b exp 0 0 1",
               if_valid, ibus_req_valid, ibus_rsp_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    bus_credit = -1;
    step(12);
    n_checks++;
    if (dpc(1) !== 32'h200 || dpc(2) !== 32'h204)
      $display("FAIL redirect_same_cycle got %h %h exp 200 204", dpc(1), dpc(2));
    else n_pass++;
  endtask

  task automatic test_fault();
    do_reset(-1);
    err_en = 1'b1;
    err_addr = 32'h8;
    if_ready = 1'b1;
    step(16);
    n_checks++;
    if (dpc(2) !== 32'h8 || dflt(2) !== 1'b1 || dflt(1) !== 1'b0)
      $display("FAIL fault_flag got pc=%h f=%b prev_f=%b exp pc=8 f=1 prev_f=0",
               dpc(2), dflt(2), dflt(1));
    else n_pass++;
    n_checks++;
    if (dpc(3) !== 32'hC || dflt(3) !== 1'b0)
      $display("FAIL fault_next got pc=%h f=%b exp pc=c f=0", dpc(3), dflt(3));
    else n_pass++;
    err_en = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset(-1);
    if_ready = 1'b0;
    step(10);
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || ibus_req_valid !== 1'b0)
      $display("FAIL full_before_rst got ifv=%b req=%b exp 1 0", if_valid, ibus_req_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || ibus_req_valid !== 1'b0)
      $display("FAIL post_rst_idle got ifv=%b req=%b exp 0 0", if_valid, ibus_req_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ibus_req_valid !== 1'b1 || ibus_req_addr !== RST_PC)
      $display("FAIL post_rst_req got req=%b addr=%h exp 1 %h",
               ibus_req_valid, ibus_req_addr, RST_PC);
    else n_pass++;
    step(10);
    n_checks++;
    if (acc_addr.size() != 2)
      $display("FAIL post_rst_capacity got %0d exp 2", acc_addr.size());
    else n_pass++;
    if_ready = 1'b1;
    step(8);
    n_checks++;
    if (dpc(0) !== 32'h0 || dpc(1) !== 32'h4)
      $display("FAIL post_rst_deliver got %h %h exp 0 4", dpc(0), dpc(1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_hold();
    test_redirect_same_cycle();
    test_fault();
    test_reset_midflight();
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
